uart_rx_deserializer: RTL and testbench

Oversampling UART receiver front end for the 8N1 serial input. It synchronises the raw rx pin into the CLK100MHZ domain, generates the oversample tick, and majority-votes each bit. It rejects false start bits, checks the stop bit, and delivers one byte per frame with a single-cycle strobe. Its rx_data/rx_done outputs feed the pipeline register and RX FIFO write port in the UART top level, and it adds frame_error and break_detect status for the controller.

---
 rtl/uart_rx_deserializer_if.sv | 33 +++
 rtl/uart_rx_deserializer.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deserializer_if.sv
`timescale 1ns/1ps
// uart_rx_deserializer_if
// Serial line and receive-status bundle for the UART receiver front end.
//   rx           : raw asynchronous serial line, idle high
//   rx_data      : last correctly received byte
//   rx_done      : one-cycle strobe, rx_data just updated
//   frame_error  : one-cycle strobe, stop bit sampled low
//   break_detect : one-cycle strobe with frame_error when the whole frame was 0
// master : the receiver (consumes rx, drives status)
// slave  : the line driver / controller side
interface uart_rx_deserializer_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_error;
  logic       break_detect;

  modport master (
    input  rx,
    output rx_data,
    output rx_done,
    output frame_error,
    output break_detect
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_done,
    input  frame_error,
    input  break_detect
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
`timescale 1ns/1ps
// uart_rx_deserializer
// 16x oversampling 8N1 UART receiver. Synchronises rx into the CLK100MHZ
// domain, majority-votes three mid-bit samples per bit, rejects false start
// bits, checks the stop bit and strobes one byte per good frame.
// Ports:
//   CLK100MHZ : system clock, rising edge
//   reset     : asynchronous, active-high
//   bus       : uart_rx_deserializer_if.master (rx in; rx_data, rx_done,
//               frame_error, break_detect out, all registered)
module uart_rx_deserializer #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset,
  uart_rx_deserializer_if.master        bus
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] tick_cnt;
  logic             running;
  logic             tick;
  logic [3:0]       s_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [2:0]       smp;
  logic             vote;
  logic             stop_vote;

  logic [7:0]       rx_data_q;
  logic             rx_done_q;
  logic             frame_error_q;
  logic             break_detect_q;

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_done      = rx_done_q;
  assign bus.frame_error  = frame_error_q;
  assign bus.break_detect = break_detect_q;

  // Two-flop synchroniser, preset to the idle level.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    running   = (state == START) || (state == DATA) || (state == STOP);
    tick      = running && (tick_cnt == DIV_LAST);
    vote      = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    // Stop decision happens on the s=9 tick itself, so the third sample is
    // the live synchronised line rather than the not-yet-stored smp[2].
    stop_vote = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  end

  // Held at 0 outside a frame so the first tick lands DIV cycles after the
  // start edge is seen and every bit period is exactly 16*DIV cycles.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (!running || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      s_cnt          <= '0;
      bit_idx        <= '0;
      shift_reg      <= '0;
      smp            <= '0;
      rx_data_q      <= '0;
      rx_done_q      <= 1'b0;
      frame_error_q  <= 1'b0;
      break_detect_q <= 1'b0;
    end else begin
      rx_done_q      <= 1'b0;
      frame_error_q  <= 1'b0;
      break_detect_q <= 1'b0;

      case (state)
        IDLE: begin
          s_cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START, DATA, STOP: begin
          if (tick) begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == 4'd7) smp[0] <= rx_s;
            if (s_cnt == 4'd8) smp[1] <= rx_s;
            if (s_cnt == 4'd9) smp[2] <= rx_s;

            case (state)
              START: begin
                if (s_cnt == 4'd15) begin
                  bit_idx <= '0;
                  state   <= vote ? IDLE : DATA;
                end
              end
              DATA: begin
                if (s_cnt == 4'd15) begin
                  shift_reg <= {vote, shift_reg[7:1]};
                  bit_idx   <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                    state <= STOP;
                  end
                end
              end
              default: begin
                if (s_cnt == 4'd9) begin
                  if (stop_vote) begin
                    rx_data_q <= shift_reg;
                    rx_done_q <= 1'b1;
                    state     <= IDLE;
                  end else begin
                    frame_error_q  <= 1'b1;
                    break_detect_q <= (shift_reg == 8'h00);
                    state          <= WAIT_HIGH;
                  end
                end
              end
            endcase
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
`timescale 1ns/1ps
// tb_uart_rx_deserializer
// Directed plus randomized frames driven onto rx at real-time bit periods
// (optionally skewed), with a frame-level expectation model: a good stop bit
// yields the byte, a low stop bit yields a frame error (break when the byte
// is zero). The receiver runs at a faster baud to keep frames short.
module tb_uart_rx_deserializer;

  localparam int unsigned CLK_FREQ = 100_000_000;
  localparam int unsigned BAUD     = 781_250;
  localparam int unsigned DIV      = CLK_FREQ / (BAUD * 16);
  localparam real         BIT_NS   = 16.0 * DIV * 10.0;
  localparam int unsigned NOM_LAT  = 2 + 16 * DIV * 9 + 10 * DIV;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_rx_deserializer_if bus ();

  uart_rx_deserializer #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(16)
  ) dut (
    .CLK100MHZ(clk),
    .reset    (reset),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events
  logic [7:0]  done_q[$];
  int unsigned done_t[$];
  logic        fe_brk_q[$];
  int          viol = 0;
  logic        prev_done = 1'b0, prev_fe = 1'b0, prev_bd = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.rx_done) begin
        done_q.push_back(bus.rx_data);
        done_t.push_back(cyc);
      end
      if (bus.frame_error) fe_brk_q.push_back(bus.break_detect);
      if (bus.rx_done && bus.frame_error) viol <= viol + 1;
      if (bus.break_detect && !bus.frame_error) viol <= viol + 1;
      if ((bus.rx_done && prev_done) || (bus.frame_error && prev_fe) ||
          (bus.break_detect && prev_bd)) viol <= viol + 1;
      if ((bus.rx_data !== prev_data) && !bus.rx_done) viol <= viol + 1;
    end
    prev_done <= bus.rx_done;
    prev_fe   <= bus.frame_error;
    prev_bd   <= bus.break_detect;
    prev_data <= bus.rx_data;
  end

  // Expected events
  logic [7:0] exp_done[$];
  logic       exp_brk[$];
  logic [7:0] model_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input real bit_ns);
    bus.rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      #(bit_ns);
    end
    bus.rx = stop_ok;
    #(bit_ns);
    bus.rx = 1'b1;
    if (stop_ok) begin
      exp_done.push_back(b);
      model_data = b;
    end else begin
      exp_brk.push_back(b == 8'h00);
    end
  endtask

  task automatic verify(input string tag);
    int n;
    chk({tag, ".n_done"}, done_q.size(), exp_done.size());
    n = (done_q.size() < exp_done.size()) ? done_q.size() : exp_done.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.data%0d", tag, i), done_q[i], exp_done[i]);
    chk({tag, ".n_ferr"}, fe_brk_q.size(), exp_brk.size());
    n = (fe_brk_q.size() < exp_brk.size()) ? fe_brk_q.size() : exp_brk.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.brk%0d", tag, i), fe_brk_q[i], exp_brk[i]);
    chk({tag, ".rx_data"}, bus.rx_data, model_data);
    done_q.delete();
    done_t.delete();
    fe_brk_q.delete();
    exp_done.delete();
    exp_brk.delete();
  endtask

  initial begin
    int unsigned t0;
    int unsigned lat;
    logic [7:0]  rb;
    bit          rok;
    bit          prev_err;
    real         f;

    bus.rx = 1'b1;
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset.rx_data", bus.rx_data, 8'h00);
    chk("reset.rx_done", bus.rx_done, 1'b0);
    chk("reset.frame_error", bus.frame_error, 1'b0);
    chk("reset.break_detect", bus.break_detect, 1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Single frame with latency measurement from the falling edge
    t0 = cyc;
    send_frame(8'hA5, 1'b1, BIT_NS);
    #(BIT_NS);
    lat = (done_t.size() > 0) ? (done_t[0] - t0) : 0;
    checks++;
    assert (lat + 1 >= NOM_LAT && lat <= NOM_LAT + 1) else begin
      failures++;
      $error("FAIL latency observed=%0d expected=%0d+-1", lat, NOM_LAT);
    end
    verify("a5");

    // Back-to-back frames
    send_frame(8'h00, 1'b1, BIT_NS);
    send_frame(8'hFF, 1'b1, BIT_NS);
    send_frame(8'h3C, 1'b1, BIT_NS);
    #(BIT_NS);
    verify("b2b");

    // Short low glitch: a false start, nothing reported
    bus.rx = 1'b0;
    #(400.0);
    bus.rx = 1'b1;
    #(3.0 * BIT_NS);
    verify("glitch");
    send_frame(8'h5A, 1'b1, BIT_NS);
    #(BIT_NS);
    verify("after_glitch");

    // Stop bit forced low, then a good frame
    send_frame(8'h81, 1'b0, BIT_NS);
    #(BIT_NS);
    verify("ferr");
    send_frame(8'h42, 1'b1, BIT_NS);
    #(BIT_NS);
    verify("after_ferr");

    // Line held low for 20 bit times: one break, then recovery
    bus.rx = 1'b0;
    #(20.0 * BIT_NS);
    bus.rx = 1'b1;
    exp_brk.push_back(1'b1);
    #(2.0 * BIT_NS);
    verify("break");
    send_frame(8'h11, 1'b1, BIT_NS);
    #(BIT_NS);
    verify("after_break");

    // Reset mid-DATA, then a 3% fast frame
    bus.rx = 1'b0;
    #(3.5 * BIT_NS);
    reset = 1'b1;
    bus.rx = 1'b1;
    #(100.0);
    @(negedge clk);
    reset = 1'b0;
    model_data = 8'h00;
    #(2.0 * BIT_NS);
    verify("reset_abort");
    send_frame(8'h7E, 1'b1, 0.97 * BIT_NS);
    #(BIT_NS);
    verify("fast_7e");

    // Random frames, random stop validity, baud skew within +-3%
    prev_err = 1'b0;
    for (int k = 0; k < 12; k++) begin
      rb  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rok = ($urandom_range(0, 3) != 0);
      f   = 0.97 + real'($urandom_range(0, 60)) / 1000.0;
      if (prev_err || ($urandom_range(0, 1) == 1))
        #(BIT_NS * real'(1 + $urandom_range(0, 1)));
      send_frame(rb, rok, f * BIT_NS);
      prev_err = !rok;
    end
    #(2.0 * BIT_NS);
    verify("random");

    chk("invariants", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
